// File: rtl/pc_pkg.sv
// pc_pkg: transfer opcodes and next-PC select encoding
// shared by the PC unit and its return-address stack.
package pc_pkg;

    localparam logic [5:0] OP_BEQ  = 6'd32;
    localparam logic [5:0] OP_BNE  = 6'd33;
    localparam logic [5:0] OP_BLTU = 6'd34;
    localparam logic [5:0] OP_BLEU = 6'd35;
    localparam logic [5:0] OP_BLT  = 6'd36;
    localparam logic [5:0] OP_BLE  = 6'd37;
    localparam logic [5:0] OP_J    = 6'd40;
    localparam logic [5:0] OP_JAL  = 6'd41;
    localparam logic [5:0] OP_JR   = 6'd42;
    localparam logic [5:0] OP_RET  = 6'd43;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BR,
        SEL_ABS,
        SEL_REG,
        SEL_RAS
    } npc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control-transfer request bundle and PC status
// master drives requests, slave (pc_unit) returns PC state.
interface pc_unit_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
);
    logic              stall;
    logic              br_valid;
    logic [5:0]        op;
    logic [DATA_W-1:0] os;
    logic [DATA_W-1:0] ot;
    logic [25:0]       addr;
    logic [DATA_W-1:0] imm_dpl;
    logic [PC_W-1:0]   pc_out;
    logic              redirect;
    logic [31:0]       cyc_cnt;
    logic              ras_ovf;
    logic              ras_udf;

    modport master (
        output stall, br_valid, op, os, ot, addr, imm_dpl,
        input  pc_out, redirect, cyc_cnt, ras_ovf, ras_udf
    );

    modport slave (
        input  stall, br_valid, op, os, ot, addr, imm_dpl,
        output pc_out, redirect, cyc_cnt, ras_ovf, ras_udf
    );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full
// overwrites the oldest entry and keeps the count saturated.
module pc_ras #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0] mem [DEPTH];
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   ptr_inc;
    logic [AW:0]     cnt;

    assign ptr_inc = ptr + AW'(1);
    assign top     = mem[ptr];
    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[ptr_inc] <= din;
            ptr          <= ptr_inc;
            if (!full)
                cnt <= cnt + (AW+1)'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - AW'(1);
            cnt <= cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: word program counter with branch/jump resolution.
// Define PC_UNIT_RAS_EN to build the return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              DATA_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    pc_unit_if.slave bus
);
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic [PC_W-1:0]          pc_q;
    logic [PC_W-1:0]          pc_inc;
    logic [PC_W-1:0]          br_tgt;
    logic [PC_W-1:0]          abs_tgt;
    logic [PC_W-1:0]          reg_tgt;
    logic [PC_W-1:0]          nxt_pc;
    logic signed [DATA_W-1:0] dpl_sh;
    logic [31:0]              cyc_q;
    logic                     redir_q;
    logic                     redir_d;
    npc_sel_e                 sel;
    logic                     eq, ltu, lts;
    logic                     ras_push, ras_pop, udf_d;
    logic [PC_W-1:0]          ras_top;
    logic                     ras_empty, ras_full;
    logic                     unused_addr;

    assign unused_addr = ^bus.addr[1:0];

    assign dpl_sh  = $signed(bus.imm_dpl) >>> 2;
    assign pc_inc  = pc_q + PC_W'(1);
    assign br_tgt  = pc_q + PC_W'(dpl_sh);
    assign abs_tgt = PC_W'(bus.addr[25:2]);
    assign reg_tgt = PC_W'(bus.os);

    assign eq  = (bus.os == bus.ot);
    assign ltu = (bus.os < bus.ot);
    assign lts = ($signed(bus.os) < $signed(bus.ot));

    // Not-taken branches and unknown ops hold the PC.
    always_comb begin
        sel      = SEL_SEQ;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        udf_d    = 1'b0;
        if (bus.stall) begin
            sel = SEL_HOLD;
        end else if (bus.br_valid) begin
            unique case (1'b1)
                bus.op == OP_BEQ:  sel = eq ? SEL_BR : SEL_HOLD;
                bus.op == OP_BNE:  sel = !eq ? SEL_BR : SEL_HOLD;
                bus.op == OP_BLTU: sel = ltu ? SEL_BR : SEL_HOLD;
                bus.op == OP_BLEU: sel = (ltu || eq) ? SEL_BR : SEL_HOLD;
                bus.op == OP_BLT:  sel = lts ? SEL_BR : SEL_HOLD;
                bus.op == OP_BLE:  sel = (lts || eq) ? SEL_BR : SEL_HOLD;
                bus.op == OP_J:    sel = SEL_ABS;
                bus.op == OP_JAL: begin
                    sel      = SEL_ABS;
                    ras_push = RAS_EN;
                end
                bus.op == OP_JR:   sel = SEL_REG;
                bus.op == OP_RET: begin
                    if (RAS_EN && !ras_empty) begin
                        sel     = SEL_RAS;
                        ras_pop = 1'b1;
                    end else begin
                        sel   = SEL_REG;
                        udf_d = RAS_EN;
                    end
                end
                default: sel = SEL_HOLD;
            endcase
        end
    end

    always_comb begin
        unique case (sel)
            SEL_HOLD: nxt_pc = pc_q;
            SEL_BR:   nxt_pc = br_tgt;
            SEL_ABS:  nxt_pc = abs_tgt;
            SEL_REG:  nxt_pc = reg_tgt;
            SEL_RAS:  nxt_pc = ras_top;
            default:  nxt_pc = pc_inc;
        endcase
    end

    assign redir_d = (sel != SEL_SEQ) && (sel != SEL_HOLD)
                  && (nxt_pc != pc_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            cyc_q   <= '0;
            redir_q <= 1'b0;
        end else begin
            pc_q    <= nxt_pc;
            cyc_q   <= cyc_q + 32'd1;
            redir_q <= redir_d;
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.cyc_cnt  = cyc_q;
    assign bus.redirect = redir_q;

`ifdef PC_UNIT_RAS_EN
    logic ovf_q;
    logic udf_q;

    pc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_q),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (ras_push & ras_full);
            udf_q <= udf_d;
        end
    end

    assign bus.ras_ovf = ovf_q;
    assign bus.ras_udf = udf_q;
`else
    logic unused_ras;

    assign ras_top     = '0;
    assign ras_empty   = 1'b1;
    assign ras_full    = 1'b0;
    assign unused_ras  = ^{ras_push, ras_pop, udf_d, ras_full};
    assign bus.ras_ovf = 1'b0;
    assign bus.ras_udf = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit; a queue-based model
// predicts PC, counter and flags, and a monitor compares each cycle.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int              PC_W      = 32;
    localparam int              DATA_W    = 32;
    localparam int              RAS_DEPTH = 4;
    localparam logic [PC_W-1:0] RESET_PC  = '0;
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

    pc_unit #(
        .PC_W      (PC_W),
        .DATA_W    (DATA_W),
        .RESET_PC  (RESET_PC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cyc;
        logic        redirect;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;

    logic [31:0] m_pc;
    logic [31:0] m_cyc;
    bit          m_ovf;
    logic [31:0] m_ras[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc  = RESET_PC;
        m_cyc = '0;
        m_ovf = 1'b0;
        m_ras.delete();
    endfunction

    // Architectural rules, one clock edge at a time.
    function automatic exp_t model_step(bit st, bit bv, logic [5:0] o,
                                        logic [31:0] s, logic [31:0] t,
                                        logic [25:0] a, logic [31:0] im);
        exp_t        e;
        bit          load = 1'b0;
        bit          udf  = 1'b0;
        logic [31:0] tgt  = m_pc;
        logic [31:0] disp = $signed(im) >>> 2;
        int          ss   = s;
        int          ts   = t;
        bit          cond = 1'b0;
        m_cyc = m_cyc + 1;
        if (!st && !bv) begin
            m_pc = m_pc + 1;
        end else if (!st) begin
            case (o)
                OP_BEQ:  cond = (s == t);
                OP_BNE:  cond = (s != t);
                OP_BLTU: cond = (s < t);
                OP_BLEU: cond = (s <= t);
                OP_BLT:  cond = (ss < ts);
                OP_BLE:  cond = (ss <= ts);
                default: cond = 1'b0;
            endcase
            if (cond) begin
                load = 1'b1;
                tgt  = m_pc + disp;
            end
            case (o)
                OP_J: begin
                    load = 1'b1;
                    tgt  = 32'(a) / 4;
                end
                OP_JAL: begin
                    if (RAS) begin
                        if (m_ras.size() == RAS_DEPTH) begin
                            m_ovf = 1'b1;
                            void'(m_ras.pop_front());
                        end
                        m_ras.push_back(m_pc);
                    end
                    load = 1'b1;
                    tgt  = 32'(a) / 4;
                end
                OP_JR: begin
                    load = 1'b1;
                    tgt  = s;
                end
                OP_RET: begin
                    load = 1'b1;
                    if (RAS && m_ras.size() > 0) begin
                        tgt = m_ras.pop_back();
                    end else begin
                        tgt = s;
                        udf = RAS;
                    end
                end
                default: ;
            endcase
        end
        e.redirect = load && (tgt != m_pc + 32'd1);
        if (load)
            m_pc = tgt;
        e.pc  = m_pc;
        e.cyc = m_cyc;
        e.ovf = m_ovf;
        e.udf = udf;
        return e;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(bit st, bit bv, logic [5:0] o, logic [31:0] s,
                        logic [31:0] t, logic [25:0] a, logic [31:0] im,
                        bit mid_rst);
        exp_t e;
        bus.stall    = st;
        bus.br_valid = bv;
        bus.op       = o;
        bus.os       = s;
        bus.ot       = t;
        bus.addr     = a;
        bus.imm_dpl  = im;
        if (mid_rst) begin
            #2 rst = 1'b1;
            #1;
            chk("arst_pc", 64'(bus.pc_out), 64'(RESET_PC));
            chk("arst_cyc", 64'(bus.cyc_cnt), 64'd0);
            chk("arst_redirect", 64'(bus.redirect), 64'd0);
            chk("arst_udf", 64'(bus.ras_udf), 64'd0);
            chk("arst_ovf", 64'(bus.ras_ovf), 64'd0);
            bus.br_valid = 1'b0;
            bv           = 1'b0;
            #1 rst = 1'b0;
            model_reset();
        end
        e = model_step(st, bv, o, s, t, a, im);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 6'd0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard: no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_out", 64'(bus.pc_out), 64'(e.pc));
                    chk("cyc_cnt", 64'(bus.cyc_cnt), 64'(e.cyc));
                    chk("redirect", 64'(bus.redirect), 64'(e.redirect));
                    chk("ras_ovf", 64'(bus.ras_ovf), 64'(e.ovf));
                    chk("ras_udf", 64'(bus.ras_udf), 64'(e.udf));
                end
            end
        end
    end

    logic [5:0]  ops  [12] = '{OP_BEQ, OP_BNE, OP_BLTU, OP_BLEU,
                               OP_BLT, OP_BLE, OP_J, OP_JAL,
                               OP_JR, OP_RET, 6'd0, 6'd50};
    logic [31:0] vals [6]  = '{32'd0, 32'd1, 32'd2, 32'hFFFFFFFF,
                               32'hFFFFFFFD, 32'h80000000};

    initial begin : driver
        bus.stall    = 1'b0;
        bus.br_valid = 1'b0;
        bus.op       = '0;
        bus.os       = '0;
        bus.ot       = '0;
        bus.addr     = '0;
        bus.imm_dpl  = '0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pc", 64'(bus.pc_out), 64'(RESET_PC));
        chk("rst_cyc", 64'(bus.cyc_cnt), 64'd0);
        chk("rst_redirect", 64'(bus.redirect), 64'd0);
        chk("rst_ovf", 64'(bus.ras_ovf), 64'd0);
        chk("rst_udf", 64'(bus.ras_udf), 64'd0);
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        repeat (5) idle();
        chk("idle_cyc5", 64'(bus.cyc_cnt), 64'd5);

        step(0, 1, OP_J, '0, '0, 26'h40, '0, 0);
        step(0, 1, OP_BLT, 32'hFFFFFFFD, 32'd2, '0, 32'hFFFFFFF8, 0);
        chk("blt_pc", 64'(bus.pc_out), 64'h0E);
        step(0, 1, OP_J, '0, '0, 26'h40, '0, 0);
        step(0, 1, OP_BLTU, 32'hFFFFFFFD, 32'd2, '0, 32'hFFFFFFF8, 0);
        chk("bltu_pc", 64'(bus.pc_out), 64'h10);

        step(1, 1, OP_J, '0, '0, 26'h100, '0, 0);
        step(1, 1, OP_J, '0, '0, 26'h100, '0, 0);
        step(0, 1, OP_J, '0, '0, 26'h100, '0, 0);
        chk("stall_j_pc", 64'(bus.pc_out), 64'h40);

        step(0, 1, OP_J, '0, '0, 26'd4, '0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 1, OP_JAL, '0, '0, 26'((i + 2) * 4), '0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 1, OP_RET, 32'h77 + 32'(i), '0, '0, '0, 0);

        step(0, 1, OP_JAL, '0, '0, 26'h80, '0, 1);
        step(0, 1, OP_RET, 32'h55, '0, '0, '0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] im;
            im = ($urandom_range(0, 3) == 0) ? $urandom()
                 : 32'($urandom_range(0, 64)) - 32'd32;
            step($urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) != 0,
                 ops[$urandom_range(0, 11)],
                 vals[$urandom_range(0, 5)],
                 vals[$urandom_range(0, 5)],
                 26'($urandom()),
                 im,
                 $urandom_range(0, 59) == 0);
        end

        repeat (2) idle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
